// File: rtl/alu_pkg.sv
// Shared op codes and FSM states for the execute-stage ALU and its
// iterative multiply/divide unit.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SLT = 3'b011,
        ALU_SLL = 3'b100,
        ALU_SRL = 3'b101,
        ALU_SRA = 3'b110,
        ALU_NOR = 3'b111
    } alu_op_e;

    typedef enum logic [2:0] {
        MD_NOP   = 3'b000,
        MD_MULT  = 3'b001,
        MD_MULTU = 3'b010,
        MD_DIV   = 3'b011,
        MD_DIVU  = 3'b100,
        MD_MTHI  = 3'b101,
        MD_MTLO  = 3'b110,
        MD_NOP7  = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } md_state_e;

endpackage

// File: rtl/alu_muldiv.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers and a sticky
// divide-by-zero flag. Optional macro: ALU_MD_EARLY_TERM_EN (multiply early exit).
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SAW   = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_md_op,
    input  logic             i_md_start,
    output logic             o_md_busy,
    output logic             o_md_done,
    output logic             o_md_dbz,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam logic [SAW-1:0] LAST_STEP = SAW'(WIDTH - 1);

    md_state_e          state, state_next;
    md_op_e             op;
    logic [SAW-1:0]     cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mc;
    logic [WIDTH-1:0]   mp;
    logic [WIDTH-1:0]   hi, lo;
    logic               is_mul, neg_q, neg_r, dbz, done;
    logic               is_signed, start_long, last_step;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     shifted, diff;

    assign op         = md_op_e'(i_md_op);
    assign is_signed  = (op == MD_MULT) || (op == MD_DIV);
    assign start_long = i_md_start &&
                        ((op == MD_MULT) || (op == MD_MULTU) ||
                         (op == MD_DIV)  || (op == MD_DIVU));
    assign a_neg      = is_signed && i_a[WIDTH-1];
    assign b_neg      = is_signed && i_b[WIDTH-1];
    assign a_mag      = a_neg ? -i_a : i_a;
    assign b_mag      = b_neg ? -i_b : i_b;

    // Restoring divide: acc holds {remainder, dividend/quotient}, mc the divisor.
    assign shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign diff    = shifted - {1'b0, mc[WIDTH-1:0]};

    always_comb begin
        last_step = (cnt == LAST_STEP);
`ifdef ALU_MD_EARLY_TERM_EN
        if (is_mul && (mp[WIDTH-1:1] == '0)) begin
            last_step = 1'b1;
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_long) state_next = CALC;
            CALC:    if (last_step)  state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt    <= '0;
            acc    <= '0;
            mc     <= '0;
            mp     <= '0;
            hi     <= '0;
            lo     <= '0;
            is_mul <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dbz    <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_md_start) begin
                        case (op)
                            MD_MTHI: hi <= i_a;
                            MD_MTLO: lo <= i_a;
                            MD_MULT, MD_MULTU: begin
                                acc    <= '0;
                                mc     <= {{WIDTH{1'b0}}, a_mag};
                                mp     <= b_mag;
                                is_mul <= 1'b1;
                                neg_q  <= a_neg ^ b_neg;
                                neg_r  <= 1'b0;
                                cnt    <= '0;
                            end
                            MD_DIV, MD_DIVU: begin
                                acc    <= {{WIDTH{1'b0}}, a_mag};
                                mc     <= {{WIDTH{1'b0}}, b_mag};
                                mp     <= i_a;
                                is_mul <= 1'b0;
                                neg_q  <= a_neg ^ b_neg;
                                neg_r  <= a_neg;
                                dbz    <= (i_b == '0);
                                cnt    <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    cnt <= cnt + SAW'(1);
                    if (is_mul) begin
                        if (mp[0]) acc <= acc + mc;
                        mc <= mc << 1;
                        mp <= mp >> 1;
                    end else if (!diff[WIDTH]) begin
                        acc <= {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                    end else begin
                        acc <= {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                    end
                end
                FIX: begin
                    done <= 1'b1;
                    if (is_mul) begin
                        {hi, lo} <= neg_q ? -acc : acc;
                    end else if (dbz) begin
                        // Zero divisor: dividend as given (held in mp), quotient all ones.
                        hi <= mp;
                        lo <= '1;
                    end else begin
                        lo <= neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                        hi <= neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_md_busy = (state != IDLE);
    assign o_md_done = done;
    assign o_md_dbz  = dbz;
    assign o_hi      = hi;
    assign o_lo      = lo;

endmodule

// File: rtl/alu_md.sv
// Execute-stage ALU: single-cycle logic/arith/shift path plus the iterative
// multiply/divide unit. Optional macro: ALU_MD_EARLY_TERM_EN (see alu_muldiv).
module alu_md
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SAW   = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [3:0]       i_alucontrol,
    input  logic [SAW-1:0]   i_sa,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero,
    input  logic [2:0]       i_md_op,
    input  logic             i_md_start,
    output logic             o_md_busy,
    output logic             o_md_done,
    output logic             o_md_dbz,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;

    // bit3 turns the adder into a subtractor for SUB/SLT/BEQ.
    assign b_eff = i_alucontrol[3] ? ~i_b : i_b;
    assign sum   = i_a + b_eff + {{(WIDTH-1){1'b0}}, i_alucontrol[3]};

    always_comb begin
        o_result = '0;
        case (alu_op_e'(i_alucontrol[2:0]))
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_ADD: o_result = sum;
            ALU_SLT: o_result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1]};
            ALU_SLL: o_result = i_b << i_sa;
            ALU_SRL: o_result = i_b >> i_sa;
            ALU_SRA: o_result = $unsigned($signed(i_b) >>> i_sa);
            ALU_NOR: o_result = ~(i_a | i_b);
            default: o_result = '0;
        endcase
    end

    assign o_zero = (o_result == '0);

    alu_muldiv #(
        .WIDTH (WIDTH),
        .SAW   (SAW)
    ) u_muldiv (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_a        (i_a),
        .i_b        (i_b),
        .i_md_op    (i_md_op),
        .i_md_start (i_md_start),
        .o_md_busy  (o_md_busy),
        .o_md_done  (o_md_done),
        .o_md_dbz   (o_md_dbz),
        .o_hi       (o_hi),
        .o_lo       (o_lo)
    );

endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md: table-driven ALU vectors plus directed
// multiply/divide sequences (latency, divide-by-zero, ignored start, reset).
module tb_alu_md;
    import alu_pkg::*;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  a, b;
    logic [3:0]    ctrl;
    logic [4:0]    sa;
    logic [W-1:0]  result;
    logic          zero;
    logic [2:0]    md_op;
    logic          md_start;
    logic          md_busy, md_done, md_dbz;
    logic [W-1:0]  hi, lo;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   ctrl;
        logic [4:0]   sa;
        logic [W-1:0] res;
        logic         zero;
    } alu_vec_t;

    alu_vec_t vecs[12];

    alu_md #(.WIDTH(W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_a          (a),
        .i_b          (b),
        .i_alucontrol (ctrl),
        .i_sa         (sa),
        .o_result     (result),
        .o_zero       (zero),
        .i_md_op      (md_op),
        .i_md_start   (md_start),
        .o_md_busy    (md_busy),
        .o_md_done    (md_done),
        .o_md_dbz     (md_dbz),
        .o_hi         (hi),
        .o_lo         (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pulse a start for exactly one edge; returns #1 after that edge (edge 0).
    task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
        md_op    = op;
        a        = av;
        b        = bv;
        md_start = 1'b1;
        tick();
        md_start = 1'b0;
        md_op    = MD_NOP;
    endtask

    // Wait for done, counting edges from e0; checks busy stays high until done.
    task automatic wait_done(input string name, input int e0, output int e);
        int busy_bad;
        busy_bad = 0;
        e = e0;
        while (!md_done && e < 100) begin
            if (!md_busy) busy_bad++;
            tick();
            e++;
        end
        checkOutput({name, "_busy_low_early"}, 64'(busy_bad), 64'd0);
        checkOutput({name, "_done_seen"}, 64'(md_done), 64'd1);
        checkOutput({name, "_busy_at_done"}, 64'(md_busy), 64'd0);
    endtask

    task automatic run_md(input string name, input logic [2:0] op, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic [W-1:0] exp_hi,
                          input logic [W-1:0] exp_lo, output int e);
        applyStimulus(op, av, bv);
        wait_done(name, 0, e);
        checkOutput({name, "_hi"}, 64'(hi), 64'(exp_hi));
        checkOutput({name, "_lo"}, 64'(lo), 64'(exp_lo));
        tick();
        checkOutput({name, "_done_pulse_one_cycle"}, 64'(md_done), 64'd0);
    endtask

    initial begin
        int e;
        int seen_done;

        rst = 1'b1; a = '0; b = '0; ctrl = '0; sa = '0; md_op = MD_NOP; md_start = 1'b0;
        tick();
        tick();
        checkOutput("reset_busy", 64'(md_busy), 64'd0);
        checkOutput("reset_done", 64'(md_done), 64'd0);
        checkOutput("reset_dbz",  64'(md_dbz),  64'd0);
        checkOutput("reset_hi",   64'(hi),      64'd0);
        checkOutput("reset_lo",   64'(lo),      64'd0);
        rst = 1'b0;
        tick();

        vecs[0]  = '{32'd5,        32'd7,        4'b1011, 5'd0, 32'h0000_0001, 1'b0};
        vecs[1]  = '{32'd5,        32'd7,        4'b1010, 5'd0, 32'hFFFF_FFFE, 1'b0};
        vecs[2]  = '{32'd7,        32'd7,        4'b1010, 5'd0, 32'h0000_0000, 1'b1};
        vecs[3]  = '{32'd0,        32'h8000_0010, 4'b0110, 5'd4, 32'hF800_0001, 1'b0};
        vecs[4]  = '{32'd0,        32'h8000_0010, 4'b0101, 5'd4, 32'h0800_0001, 1'b0};
        vecs[5]  = '{32'd0,        32'h8000_0010, 4'b0100, 5'd4, 32'h0000_0100, 1'b0};
        vecs[6]  = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0000, 5'd0, 32'h00F0_00F0, 1'b0};
        vecs[7]  = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0001, 5'd0, 32'hFFF0_FFF0, 1'b0};
        vecs[8]  = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0111, 5'd0, 32'h000F_000F, 1'b0};
        vecs[9]  = '{32'hFFFF_FFFF, 32'd1,        4'b0010, 5'd0, 32'h0000_0000, 1'b1};
        vecs[10] = '{32'd7,        32'd5,        4'b1011, 5'd0, 32'h0000_0000, 1'b1};
        vecs[11] = '{32'd0,        32'h7FFF_FFFF, 4'b0110, 5'd31, 32'h0000_0000, 1'b1};

        for (int i = 0; i < 12; i++) begin
            a    = vecs[i].a;
            b    = vecs[i].b;
            ctrl = vecs[i].ctrl;
            sa   = vecs[i].sa;
            #1;
            checkOutput($sformatf("alu_vec%0d_result", i), 64'(result), 64'(vecs[i].res));
            checkOutput($sformatf("alu_vec%0d_zero", i),   64'(zero),   64'(vecs[i].zero));
        end
        tick();

        run_md("mult_neg3x7", MD_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, e);
`ifndef ALU_MD_EARLY_TERM_EN
        checkOutput("mult_latency", 64'(e), 64'd33);
`else
        checkOutput("mult_latency_early", 64'(e < 33), 64'd1);
`endif
        run_md("multu_fffffffd_x7", MD_MULTU, 32'hFFFF_FFFD, 32'd7, 32'h0000_0006, 32'hFFFF_FFEB, e);
        run_md("div_neg7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, e);
        checkOutput("div_latency", 64'(e), 64'd33);
        run_md("div_min_neg1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, e);
        checkOutput("div_min_neg1_dbz", 64'(md_dbz), 64'd0);

        run_md("divu_by_zero", MD_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, e);
        checkOutput("divu_by_zero_dbz", 64'(md_dbz), 64'd1);
        checkOutput("divu_by_zero_latency", 64'(e), 64'd33);
        applyStimulus(MD_DIVU, 32'd9, 32'd2);
        checkOutput("divu_dbz_cleared_at_start", 64'(md_dbz), 64'd0);
        wait_done("divu_9_2", 0, e);
        checkOutput("divu_9_2_hi", 64'(hi), 64'd1);
        checkOutput("divu_9_2_lo", 64'(lo), 64'd4);
        tick();

        // Second start during a MULT must be dropped.
        applyStimulus(MD_MULT, 32'hFFFF_FFFD, 32'd7);
        for (int i = 0; i < 4; i++) tick();
        applyStimulus(MD_DIVU, 32'd9, 32'd2);
        wait_done("mult_ignored_start", 5, e);
`ifndef ALU_MD_EARLY_TERM_EN
        checkOutput("mult_ignored_start_latency", 64'(e), 64'd33);
`endif
        checkOutput("mult_ignored_start_hi", 64'(hi), 64'hFFFF_FFFF);
        checkOutput("mult_ignored_start_lo", 64'(lo), 64'hFFFF_FFEB);
        tick();
        tick();
        checkOutput("mult_ignored_start_no_second_op", 64'(md_busy), 64'd0);

        applyStimulus(MD_MTLO, 32'h0000_1234, 32'd0);
        checkOutput("mtlo_lo",   64'(lo),      64'h1234);
        checkOutput("mtlo_done", 64'(md_done), 64'd0);
        checkOutput("mtlo_busy", 64'(md_busy), 64'd0);
        applyStimulus(MD_MTHI, 32'h0000_5678, 32'd0);
        checkOutput("mthi_hi",   64'(hi),      64'h5678);
        checkOutput("mthi_busy", 64'(md_busy), 64'd0);
        tick();

        run_md("multu_5x3", MD_MULTU, 32'd5, 32'd3, 32'd0, 32'd15, e);
`ifdef ALU_MD_EARLY_TERM_EN
        checkOutput("multu_5x3_early", 64'(e < 33), 64'd1);
`else
        checkOutput("multu_5x3_latency", 64'(e), 64'd33);
`endif
        run_md("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, e);
        checkOutput("multu_max_latency", 64'(e), 64'd33);

        // Reset on cycle 10 of a DIV discards everything.
        applyStimulus(MD_DIV, 32'd1000, 32'd7);
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        tick();
        checkOutput("rst_mid_busy", 64'(md_busy), 64'd0);
        checkOutput("rst_mid_hi",   64'(hi),      64'd0);
        checkOutput("rst_mid_lo",   64'(lo),      64'd0);
        checkOutput("rst_mid_done", 64'(md_done), 64'd0);
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (md_done) seen_done++;
        end
        checkOutput("rst_mid_no_done_later", 64'(seen_done), 64'd0);
        checkOutput("rst_mid_lo_stays_zero", 64'(lo), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
